subbit_serial: RTL

SUBBIT_SERIAL -- requirements
Module: subbit_serial

---
 rtl/subbit_serial.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/subbit_serial.sv
// Bit-serial subtractor: computes diff = a - b - bi (mod 2^WIDTH) one bit per
// clock, LSB first, and reports the unsigned borrow-out and the signed overflow.
// A three-state controller (IDLE / RUN / DONE) sequences each operation; a new
// request may be accepted directly from DONE so operations can run back-to-back.
module subbit_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One full-subtractor step: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_bit(input logic a_bit,
                                           input logic b_bit,
                                           input logic br_in);
        logic d_bit;
        logic br_out;
        d_bit  = a_bit ^ b_bit ^ br_in;
        br_out = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_in);
        return {br_out, d_bit};
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q, bo_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       step_s;

    // Next-state, datapath-step and result-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bo_d    = bo_q;
        ovf_d   = ovf_q;
        step_s  = sub_bit(a_sh_q[0], b_sh_q[0], br_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Capture operands now; later input changes cannot disturb the run.
                    state_d = ST_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bi;
                    cnt_d   = '0;
                    res_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Consume the LSB of each operand and push the new bit in at the
                // top so bit i settles at position i after WIDTH shifts.
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = step_s[1];
                res_d  = {step_s[0], res_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // br_q is the borrow into the MSB, step_s[1] the borrow out.
                    state_d = ST_DONE;
                    diff_d  = {step_s[0], res_q[WIDTH-1:1]};
                    bo_d    = step_s[1];
                    ovf_d   = br_q ^ step_s[1];
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bo   = bo_q;
    assign ovf  = ovf_q;

endmodule
